// File: rtl/key_pkg.sv
// Shared constants, repeat-FSM encoding and counter sizing helper for the key front end.
package key_pkg;

    localparam int unsigned DB_CYCLES_DEF     = 200000;
    localparam int unsigned HOLD_CYCLES_DEF   = 5000000;
    localparam int unsigned REPEAT_CYCLES_DEF = 2000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Never returns 0 so a terminal count of 1 still gets a real register bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce counter, debounced state and press pulse.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          st;
    logic [CW-1:0] cnt;
    logic          flip;

    // rise/fall are the combinational strobes of the edge on which st is about to change.
    assign flip  = (s2 != st) && (cnt == CNT_LAST);
    assign rise  = flip && s2;
    assign fall  = flip && !s2;
    assign level = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            st    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= rise;
            if (s2 == st) begin
                cnt <= '0;
            end else if (flip) begin
                st  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_input.sv
// Debounced mode/add key front end; add auto-repeats while held, mode pulses once per press.
module key_input
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_mode_raw,
    input  logic key_add_raw,
    output logic key_mode,
    output logic key_add,
    output logic key_mode_level,
    output logic key_add_level
);

    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = cnt_w(HMAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

    logic mode_press;
    logic mode_rise_unused;
    logic mode_fall_unused;
    logic add_press;
    logic add_rise;
    logic add_fall;

    rpt_state_e    state;
    rpt_state_e    state_next;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_next;
    logic          rpt_pulse;
    logic          rpt_pulse_next;

    key_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_mode_raw),
        .level (key_mode_level),
        .press (mode_press),
        .rise  (mode_rise_unused),
        .fall  (mode_fall_unused)
    );

    key_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_add_raw),
        .level (key_add_level),
        .press (add_press),
        .rise  (add_rise),
        .fall  (add_fall)
    );

    assign key_mode = mode_press;
    assign key_add  = add_press | rpt_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            rpt_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            hcnt      <= hcnt_next;
            rpt_pulse <= rpt_pulse_next;
        end
    end

    // The fall strobe is checked first so a release cancels a repeat due on the same edge.
    always_comb begin
        state_next     = state;
        hcnt_next      = hcnt;
        rpt_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                hcnt_next = '0;
                if (add_rise) state_next = HELD;
            end
            HELD: begin
                if (add_fall) begin
                    state_next = IDLE;
                    hcnt_next  = '0;
                end else if (hcnt == HOLD_LAST) begin
                    rpt_pulse_next = 1'b1;
                    hcnt_next      = '0;
                    state_next     = REPEAT;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (add_fall) begin
                    state_next = IDLE;
                    hcnt_next  = '0;
                end else if (hcnt == RPT_LAST) begin
                    rpt_pulse_next = 1'b1;
                    hcnt_next      = '0;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                hcnt_next  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with small cycle constants; expectations derived from press/release edge numbers.
module tb_key_input;

    localparam int DB = 4;
    localparam int H  = 10;
    localparam int R  = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic key_mode_raw;
    logic key_add_raw;
    logic key_mode;
    logic key_add;
    logic key_mode_level;
    logic key_add_level;

    typedef struct packed {
        logic m;
        logic a;
        logic ml;
        logic al;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   c     = 0;
    int   pm, fm, pa, fa;
    bit   in_rst;

    key_input #(.DB_CYCLES(DB), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_mode_raw   (key_mode_raw),
        .key_add_raw    (key_add_raw),
        .key_mode       (key_mode),
        .key_add        (key_add),
        .key_mode_level (key_mode_level),
        .key_add_level  (key_add_level)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // p = edge of the press pulse (0: no press), f = edge on which the level drops.
    function automatic logic exp_pulse(input int cc, input int p, input int f, input bit rep);
        int d;
        if (p == 0 || cc < p || cc >= f) return 1'b0;
        if (cc == p) return 1'b1;
        if (!rep) return 1'b0;
        d = cc - p;
        if (d < H) return 1'b0;
        return ((d - H) % R) == 0;
    endfunction

    function automatic logic exp_level(input int cc, input int p, input int f);
        return (p != 0) && (cc >= p) && (cc < f);
    endfunction

    task automatic start(input int p_m, input int f_m, input int p_a, input int f_a);
        pm = p_m; fm = f_m; pa = p_a; fa = f_a;
        c  = 0;
    endtask

    task automatic cycle(input logic m, input logic a, input string tag);
        exp_t e;
        exp_t w;
        string t;
        key_mode_raw = m;
        key_add_raw  = a;
        c++;
        if (in_rst) e = '0;
        else begin
            e.m  = exp_pulse(c, pm, fm, 1'b0);
            e.a  = exp_pulse(c, pa, fa, 1'b1);
            e.ml = exp_level(c, pm, fm);
            e.al = exp_level(c, pa, fa);
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        w = sb.pop_front();
        t = $sformatf("%s@%0d", tag, c);
        chk({t, " key_mode"}, key_mode, w.m);
        chk({t, " key_add"}, key_add, w.a);
        chk({t, " key_mode_level"}, key_mode_level, w.ml);
        chk({t, " key_add_level"}, key_add_level, w.al);
    endtask

    initial begin
        rst_n        = 1'b0;
        key_mode_raw = 1'b0;
        key_add_raw  = 1'b0;
        in_rst       = 1'b1;
        start(0, 0, 0, 0);

        // Reset held with raw inputs toggling.
        for (int i = 0; i < 6; i++) cycle(i[0], ~i[0], "reset");

        // Release with inputs idle.
        rst_n  = 1'b1;
        in_rst = 1'b0;
        start(0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b0, "idle");

        // Clean add press held 8 cycles: pulse at 6, level drops at 9+5=14.
        start(0, 0, 6, 14);
        for (int k = 1; k <= 20; k++) cycle(1'b0, k <= 8, "press");

        // Mode glitch train: never stable long enough.
        start(0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) cycle((k <= 3) || (k >= 5 && k <= 7), 1'b0, "glitch");

        // Add held 40 cycles: repeats at 16..41, the one due at 46 is cancelled by the fall.
        start(0, 0, 6, 46);
        for (int k = 1; k <= 55; k++) cycle(1'b0, k <= 40, "repeat");

        // Both keys together for 30 cycles.
        start(6, 36, 6, 36);
        for (int k = 1; k <= 45; k++) cycle(k <= 30, k <= 30, "both");

        // Reset while add is in the repeat phase.
        start(0, 0, 6, 1000);
        for (int k = 1; k <= 18; k++) cycle(1'b0, 1'b1, "midhold");
        rst_n = 1'b0;
        #1;
        chk("rst_async key_mode", key_mode, 1'b0);
        chk("rst_async key_add", key_add, 1'b0);
        chk("rst_async key_mode_level", key_mode_level, 1'b0);
        chk("rst_async key_add_level", key_add_level, 1'b0);
        in_rst = 1'b1;
        for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, "inrst");

        // Raw still high at release: fresh press at 6, first repeat at 16.
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        start(0, 0, 6, 26);
        for (int k = 1; k <= 32; k++) cycle(1'b0, k <= 20, "rearm");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
